sequence_burst_scheduler: RTL and testbench
===========================================

# sequence_burst_scheduler

- Shares one `sequence_generator` between `NUM_REQ` requesters.
- Each requester asks for a burst of 1..16 bytes.
- The scheduler grants requesters round-robin and drives the generator's `enable` for exactly the granted number of accepted beats.
- It forwards the generator bytes to a single valid/ready output stream, tagged with requester id and last-beat marker.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `LEN_W`, 4: burst length field width. Burst length = `req_len + 1`.
- `DATA_W`, 8: generator data width.
- `ID_W`: derived, `$clog2(NUM_REQ)`. Not overridable.

Ports:
- `clk` in 1: clock. All logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester burst request. Must be held until its `req_ready`.
- `req_len` in `NUM_REQ*LEN_W`: packed lengths. Requester i uses bits `[i*LEN_W +: LEN_W]`.
- `req_ready` out `NUM_REQ`: one-hot grant pulse. Asserted in the cycle the request is accepted.
- `gen_enable` out 1: advance command to the generator.
- `gen_data` in `DATA_W`: the generator's current element.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: sink accepts the beat.
- `out_data` out `DATA_W`: beat payload.
- `out_id` out `ID_W`: id of the requester owning the current burst.
- `out_last` out 1: final beat of the burst.
- `done` out `NUM_REQ`: one-hot, one-cycle pulse after a burst's last beat transfers.
- `busy` out 1: high while in BURST.

## Operation

- FSM has two states, IDLE and BURST. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is set, the round-robin arbiter picks winner w.
  - Search starts at `rr_ptr` and ascends modulo `NUM_REQ`.
  - In that cycle: `req_ready[w]=1`, latch `id=w`, latch `cnt=req_len[w]`, set `rr_ptr=(w+1) mod NUM_REQ`.
  - Next state is BURST.
  - If no request is pending, stay in IDLE with all outputs low.
- **BURST**
  - `out_valid=1`, `out_data=gen_data` (combinational pass-through), `out_id=id`, `out_last=(cnt==0)`.
  - Transfer occurs when `out_valid && out_ready`.
  - `gen_enable = out_valid && out_ready`, so the generator advances only on accepted beats. Backpressure stalls the generator with no beat lost or duplicated.
  - On a non-last transfer: `cnt` decrements.
  - On the last transfer: next state is IDLE, and `done[id]` pulses in the following cycle.
- Arbitration in IDLE does not depend on `done`. A new grant may occur in the same cycle that `done` pulses.
- The generator is never reset or rewound by this block. Consecutive bursts continue the generator's sequence where the previous burst stopped.
- Length rules:
  - `req_len` is sampled only at grant. Changes after grant are ignored.
  - `req_len=0` gives 1 beat; `req_len=15` gives 16 beats.
  - `cnt` is `LEN_W` bits wide and never underflows.
- Dropping `req_valid` before `req_ready` is a protocol violation; behaviour is unspecified.

## Timing

- Reset values:
  - `req_ready=0`, `gen_enable=0`, `out_valid=0`, `out_last=0`, `done=0`, `busy=0`.
  - `out_id=0`, `out_data=gen_data` (don't-care while invalid), `rr_ptr=0`, state IDLE.
- Grant latency: `req_ready` is in the same cycle as the first sampled `req_valid` in IDLE. The first `out_valid` follows one cycle later.
- Throughput: one beat per cycle while `out_ready=1`. One idle bubble cycle between consecutive bursts.
- `done` arrives one cycle after the last transfer.
- Simultaneous requests are resolved purely by `rr_ptr`. A continuously requesting port cannot starve another.
- Reset mid-burst aborts the burst.
  - Next cycle: all outputs are at reset values, `rr_ptr=0`.
  - No `done` pulse is issued for the aborted burst.
  - Generator position is whatever was reached.
- `out_ready` toggling in BURST never alters `cnt`, `id` or state without a transfer.

## Structure

- Package `seq_sched_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_BURST`);
  - `DATA_W` default;
  - `MAX_BURST = 16`.
- Sub-module `rr_arbiter`: combinational rotate-priority picker with inputs `req[NUM_REQ]` and `ptr[ID_W]`, outputs `gnt` (one-hot) and `gnt_id`.
- The scheduler itself holds the FSM, `cnt`, `id`, `rr_ptr` and the `done` register.

## Test plan

The bench generator model repeats AF BC E2 78 FF E2 0B 8D and advances on `gen_enable`. Reset the model with the DUT.

1. Reset, then `req_valid[0]=1`, `req_len0=2`, `out_ready=1` → `req_ready=0001`; next cycles `out_data` AF, BC, E2 with `out_id=0`; `out_last` only on E2; `done=0001` one cycle later.
2. All four requesters, len 0, asserted together after reset → grants in order 0, 1, 2, 3 with one bubble between each; beats AF, BC, E2, 78 with ids 0, 1, 2, 3.
3. Requester 1, len 3, `out_ready` low for 3 cycles after the first beat → `gen_enable=0` and `out_data` held at BC during the stall; total beats AF, BC, E2, 78, none repeated.
4. `req_len=15` → 16 beats (sequence wraps twice, ending 8D); `out_last` only on beat 16; `cnt` never wraps.
5. Requesters 0 and 2 held continuously, len 0 → grant ids alternate 0, 2, 0, 2; requester 2 is never starved.
6. `reset` asserted on beat 2 of a 5-beat burst → next cycle `out_valid=0`, `busy=0`, no `done`; after reset release a still-pending request is granted normally starting at `rr_ptr=0`.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared FSM state type and sizing constants for the sequence burst scheduler.
package seq_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int MAX_BURST      = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority picker: the first set request at or above ptr (mod NUM_REQ) wins.
// Purely combinational; no state and no backpressure.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sequence_burst_scheduler.sv
// Round-robin burst scheduler sharing one sequence generator; grant in IDLE, first beat next cycle.
// Generator advances only on accepted beats, so out_ready backpressure stalls it losslessly.
module sequence_burst_scheduler
  import seq_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int LEN_W   = 4,
  parameter  int DATA_W  = DEFAULT_DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     gen_enable,
  input  logic [DATA_W-1:0]        gen_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  state_t             state;
  logic [ID_W-1:0]    id;
  logic [ID_W-1:0]    rr_ptr;
  logic [LEN_W-1:0]   cnt;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [LEN_W-1:0]   sel_len;
  logic               xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Grant is suppressed while reset is held so no request is acknowledged without being taken.
  assign req_ready  = (state == ST_IDLE && !reset) ? gnt : '0;
  assign busy       = (state == ST_BURST);
  assign out_valid  = busy;
  assign xfer       = out_valid && out_ready;
  assign gen_enable = xfer;
  assign out_data   = gen_data;
  assign out_id     = busy ? id : '0;
  assign out_last   = busy && (cnt == '0);
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      id     <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      done_q <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            id     <= gnt_id;
            cnt    <= sel_len;
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (xfer) begin
            if (cnt == '0) begin
              state  <= ST_IDLE;
              done_q <= NUM_REQ'(1) << id;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_burst_scheduler.sv
// Bench for sequence_burst_scheduler: directed scenarios plus a randomized run against a reference model.
module tb_sequence_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_len;
  logic [3:0]  req_ready;
  logic        gen_enable;
  logic [7:0]  gen_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic [3:0]  done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  int gidx;
  int cyc = 0;
  logic [3:0] sticky;
  logic [3:0] last_gnt;

  logic [7:0] q_data[$];
  logic [1:0] q_id[$];
  logic       q_last[$];
  int         q_beat_cyc[$];
  logic [3:0] q_gnt[$];
  int         q_gnt_cyc[$];
  logic [3:0] q_done[$];
  int         q_done_cyc[$];

  sequence_burst_scheduler #(.NUM_REQ(4), .LEN_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .gen_enable (gen_enable),
    .gen_data   (gen_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Generator model: repeating pattern, advances on gen_enable, restarts with reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) gidx <= 0;
    else if (gen_enable) gidx <= (gidx + 1) % 8;
  end
  assign gen_data = pat[gidx];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_id.push_back(out_id);
      q_last.push_back(out_last);
      q_beat_cyc.push_back(cyc);
    end
    if (|req_ready) begin
      q_gnt.push_back(req_ready);
      q_gnt_cyc.push_back(cyc);
    end
    if (|done) begin
      q_done.push_back(done);
      q_done_cyc.push_back(cyc);
    end
  end

  task automatic clear_q;
    q_data.delete(); q_id.delete(); q_last.delete(); q_beat_cyc.delete();
    q_gnt.delete(); q_gnt_cyc.delete(); q_done.delete(); q_done_cyc.delete();
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; out_ready = 1'b0; sticky = '0; last_gnt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_q();
  endtask

  // Requests are dropped the cycle after their grant unless marked sticky.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      last_gnt = req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~(last_gnt & ~sticky);
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
    n_checks++; if (gen_enable !== 1'b0) begin n_fail++; $display("FAIL reset_gen_enable got %b want 0", gen_enable); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_checks++; if (done !== 4'h0) begin n_fail++; $display("FAIL reset_done got %h want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0;
    @(negedge clk);
    n_checks++; if ({busy, out_valid, req_ready} !== 6'b0) begin n_fail++; $display("FAIL idle_outputs got %b want 0", {busy, out_valid, req_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    do_reset();
    out_ready = 1'b1; req_len = 16'h0002; req_valid = 4'b0001;
    run_cycles(7);
    n_checks++; if (q_gnt.size() != 1 || q_gnt[0] !== 4'b0001) begin n_fail++; $display("FAIL single_grant got n=%0d g=%h want n=1 g=1", q_gnt.size(), q_gnt[0]); end
    n_checks++; if (q_data.size() != 3) begin n_fail++; $display("FAIL single_beats got %0d want 3", q_data.size()); end
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (q_data[j] !== pat[j] || q_id[j] !== 2'd0 || q_last[j] !== (j == 2)) begin
        n_fail++; $display("FAIL single_beat%0d got d=%h id=%0d l=%b want d=%h id=0 l=%b", j, q_data[j], q_id[j], q_last[j], pat[j], j == 2);
      end
    end
    n_checks++; if (q_beat_cyc[0] !== q_gnt_cyc[0] + 1) begin n_fail++; $display("FAIL single_first_beat_lat got %0d want %0d", q_beat_cyc[0], q_gnt_cyc[0] + 1); end
    n_checks++; if (q_done.size() != 1 || q_done[0] !== 4'b0001 || q_done_cyc[0] !== q_beat_cyc[2] + 1) begin
      n_fail++; $display("FAIL single_done got n=%0d v=%h c=%0d want n=1 v=1 c=%0d", q_done.size(), q_done[0], q_done_cyc[0], q_beat_cyc[2] + 1);
    end
  endtask

  task automatic test_all_four;
    do_reset();
    out_ready = 1'b1; req_len = 16'h0000; req_valid = 4'b1111;
    run_cycles(12);
    n_checks++; if (q_gnt.size() != 4) begin n_fail++; $display("FAIL four_grant_count got %0d want 4", q_gnt.size()); end
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (q_gnt[j] !== (4'b0001 << j) || q_data[j] !== pat[j] || q_id[j] !== 2'(j) || q_last[j] !== 1'b1) begin
        n_fail++; $display("FAIL four_burst%0d got g=%h d=%h id=%0d l=%b want g=%h d=%h id=%0d l=1", j, q_gnt[j], q_data[j], q_id[j], q_last[j], 4'b0001 << j, pat[j], j);
      end
    end
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (q_gnt_cyc[j+1] - q_gnt_cyc[j] != 2) begin n_fail++; $display("FAIL four_bubble%0d got %0d want 2", j, q_gnt_cyc[j+1] - q_gnt_cyc[j]); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b1; req_len = 16'h0030; req_valid = 4'b0010;
    run_cycles(2);
    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL bp_first_beat got %0d beats want 1", q_data.size()); end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_checks++; if (gen_enable !== 1'b0 || out_data !== 8'hBC || out_valid !== 1'b1 || out_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall%0d got en=%b d=%h v=%b l=%b want en=0 d=bc v=1 l=0", s, gen_enable, out_data, out_valid, out_last);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    run_cycles(8);
    n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL bp_beats got %0d want 4", q_data.size()); end
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (q_data[j] !== pat[j] || q_id[j] !== 2'd1) begin n_fail++; $display("FAIL bp_beat%0d got d=%h id=%0d want d=%h id=1", j, q_data[j], q_id[j], pat[j]); end
    end
  endtask

  task automatic test_max_len;
    do_reset();
    out_ready = 1'b1; req_len = 16'h000F; req_valid = 4'b0001;
    run_cycles(22);
    n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL max_beats got %0d want 16", q_data.size()); end
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (q_data[j] !== pat[j % 8] || q_last[j] !== (j == 15)) begin
        n_fail++; $display("FAIL max_beat%0d got d=%h l=%b want d=%h l=%b", j, q_data[j], q_last[j], pat[j % 8], j == 15);
      end
    end
    n_checks++; if (q_data[15] !== 8'h8D) begin n_fail++; $display("FAIL max_final got %h want 8d", q_data[15]); end
  endtask

  task automatic test_fairness;
    do_reset();
    out_ready = 1'b1; req_len = 16'h0000; sticky = 4'b0101; req_valid = 4'b0101;
    run_cycles(10);
    n_checks++; if (q_gnt.size() < 4) begin n_fail++; $display("FAIL fair_count got %0d want >=4", q_gnt.size()); end
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (q_gnt[j] !== ((j % 2 == 0) ? 4'b0001 : 4'b0100)) begin
        n_fail++; $display("FAIL fair_grant%0d got %h want %h", j, q_gnt[j], (j % 2 == 0) ? 4'b0001 : 4'b0100);
      end
    end
    sticky = '0; req_valid = '0;
    run_cycles(3);
  endtask

  task automatic test_reset_mid;
    do_reset();
    out_ready = 1'b1; req_len = 16'h0004; req_valid = 4'b0001;
    run_cycles(2);
    reset = 1'b1; req_valid = 4'b0101; req_len = 16'h0100;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'h0 || out_data !== 8'hBC) begin n_fail++; $display("FAIL mid_beat2 got g=%h d=%h want g=0 d=bc", req_ready, out_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_q();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 4'h0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort got v=%b b=%b dn=%h l=%b want all 0", out_valid, busy, done, out_last);
    end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant got %h want 1", req_ready); end
    last_gnt = req_ready;
    @(posedge clk); #1;
    req_valid = req_valid & ~last_gnt;
    run_cycles(8);
    n_checks++; if (q_gnt.size() != 2 || q_gnt[0] !== 4'b0001 || q_gnt[1] !== 4'b0100) begin
      n_fail++; $display("FAIL mid_grants got n=%0d %h %h want 1 4", q_gnt.size(), q_gnt[0], q_gnt[1]);
    end
    n_checks++; if (q_data.size() != 3 || q_data[0] !== 8'hAF || q_data[1] !== 8'hBC || q_data[2] !== 8'hE2 || q_id[0] !== 2'd0 || q_id[2] !== 2'd2) begin
      n_fail++; $display("FAIL mid_beats got n=%0d %h %h %h want 3 af bc e2", q_data.size(), q_data[0], q_data[1], q_data[2]);
    end
    n_checks++; if (q_done.size() != 2 || q_done[0] !== 4'b0001 || q_done[1] !== 4'b0100) begin
      n_fail++; $display("FAIL mid_done got n=%0d %h %h want 1 4", q_done.size(), q_done[0], q_done[1]);
    end
  endtask

  // Reference model: bursts of len+1 beats, each byte the next pattern element since reset,
  // winner is the first pending port at or after the pointer, done one cycle after the last beat.
  task automatic test_random;
    bit         inb;
    int         cur, rem, rr, k, w;
    logic [3:0] exp_gnt, exp_done;
    do_reset();
    inb = 0; cur = 0; rem = 0; rr = 0; k = 0; exp_done = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i]) begin
          req_len[i*4 +: 4] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 4) == 0) req_valid[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_gnt = '0; w = 0;
      if (!inb) begin
        for (int j = 3; j >= 0; j--) begin
          if (req_valid[(rr + j) % 4]) w = (rr + j) % 4;
        end
        if (|req_valid) exp_gnt = 4'b0001 << w;
      end
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rnd_grant c=%0d got %h want %h", c, req_ready, exp_gnt); end
      n_checks++; if (busy !== inb || out_valid !== inb) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b/%b want %b", c, busy, out_valid, inb); end
      n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL rnd_done c=%0d got %h want %h", c, done, exp_done); end
      if (inb) begin
        n_checks++; if (out_data !== pat[k % 8] || out_id !== 2'(cur) || out_last !== (rem == 1) || gen_enable !== out_ready) begin
          n_fail++; $display("FAIL rnd_beat c=%0d got d=%h id=%0d l=%b en=%b want d=%h id=%0d l=%b en=%b",
                             c, out_data, out_id, out_last, gen_enable, pat[k % 8], cur, rem == 1, out_ready);
        end
      end
      exp_done = '0;
      if (!inb && |exp_gnt) begin
        inb = 1; cur = w; rem = int'(req_len[w*4 +: 4]) + 1; rr = (w + 1) % 4;
      end else if (inb && out_ready) begin
        k++; rem--;
        if (rem == 0) begin inb = 0; exp_done = 4'b0001 << cur; end
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~exp_gnt;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_len = '0; out_ready = 1'b0; sticky = '0; last_gnt = '0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_max_len();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
